// File: rtl/axi4_slaver_mem_model_if.sv
// AXI4 bus interface bundling the AW, W, B, AR and R channels.
// Widths come from the interface parameters. The slaver modport is the
// responder side and the master modport is the requester side.
interface axi_inf #(
  parameter int IDSIZE = 4,
  parameter int ASIZE  = 32,
  parameter int LSIZE  = 8,
  parameter int DSIZE  = 32,
  parameter     MODE   = "BOTH"
);
  // write address channel
  logic [IDSIZE-1:0]  awid;
  logic [ASIZE-1:0]   awaddr;
  logic [LSIZE-1:0]   awlen;
  logic [2:0]         awsize;
  logic [1:0]         awburst;
  logic               awlock;
  logic [3:0]         awcache;
  logic [2:0]         awprot;
  logic [3:0]         awqos;
  logic               awvalid;
  logic               awready;
  // write data channel
  logic [DSIZE-1:0]   wdata;
  logic [DSIZE/8-1:0] wstrb;
  logic               wlast;
  logic               wvalid;
  logic               wready;
  // write response channel
  logic [IDSIZE-1:0]  bid;
  logic [1:0]         bresp;
  logic               bvalid;
  logic               bready;
  // read address channel
  logic [IDSIZE-1:0]  arid;
  logic [ASIZE-1:0]   araddr;
  logic [LSIZE-1:0]   arlen;
  logic [2:0]         arsize;
  logic [1:0]         arburst;
  logic               arlock;
  logic [3:0]         arcache;
  logic [2:0]         arprot;
  logic [3:0]         arqos;
  logic               arvalid;
  logic               arready;
  // read data channel
  logic [IDSIZE-1:0]  rid;
  logic [DSIZE-1:0]   rdata;
  logic [1:0]         rresp;
  logic               rlast;
  logic               rvalid;
  logic               rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slaver (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4_slaver_mem_model.sv
// AXI4 responder backed by a word-addressed RAM of 2^DEPTH_LOG words.
// Independent write (AW/W/B) and read (AR/R) state machines share one RAM
// with a single write port and a registered, read-first read port.
// Optional feature macro: AXI4_MEM_MODEL_SLVERR_EN -- when defined, WRAP
// bursts, a size other than the full bus width, or a misplaced wlast
// return SLVERR; when undefined all responses are OKAY.
module axi4_slaver_mem_model #(
  parameter int DEPTH_LOG = 10
) (
  input  logic   clock,
  input  logic   rst,
  axi_inf.slaver slaver
);
  localparam int DSIZE  = slaver.DSIZE;
  localparam int IDSIZE = slaver.IDSIZE;
  localparam int ASIZE  = slaver.ASIZE;
  localparam int LSIZE  = slaver.LSIZE;
  localparam int NBYTES = DSIZE / 8;
  localparam int BSHIFT = $clog2(NBYTES);
  localparam bit MODE_OK = (slaver.MODE == "BOTH");
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] RESP_OKAY   = 2'b00;

  typedef logic [DEPTH_LOG-1:0] idx_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  // Byte address to word index; high bits beyond the RAM alias.
  function automatic idx_t addr_to_idx(input logic [ASIZE-1:0] addr);
    return idx_t'(addr >> BSHIFT);
  endfunction

  // FIXED stays on one word; INCR and WRAP both step by one word.
  function automatic idx_t next_idx(input idx_t idx, input logic [1:0] burst);
    return (burst == BURST_FIXED) ? idx : idx + idx_t'(1);
  endfunction

  logic [DSIZE-1:0] mem [0:(1<<DEPTH_LOG)-1];

  // ---------------- write side ----------------
  w_state_t          w_state, w_state_nxt;
  logic [IDSIZE-1:0] w_id;
  idx_t              w_idx;
  logic [LSIZE-1:0]  w_len, w_cnt;
  logic [1:0]        w_burst;
  logic              aw_hs, w_hs, b_hs, w_last_beat;

  assign aw_hs       = slaver.awvalid && slaver.awready;
  assign w_hs        = slaver.wvalid  && slaver.wready;
  assign b_hs        = slaver.bvalid  && slaver.bready;
  assign w_last_beat = (w_cnt == w_len);

  // write FSM state register
  always_ff @(posedge clock or posedge rst) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_state_nxt;
  end

  // write FSM next state: burst length alone decides when data ends
  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_state_nxt = W_RESP;
      W_RESP:  if (b_hs) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // latch write burst attributes, then step address and beat count
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      w_id    <= '0;
      w_idx   <= '0;
      w_len   <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
    end else if (aw_hs) begin
      w_id    <= slaver.awid;
      w_idx   <= addr_to_idx(slaver.awaddr);
      w_len   <= slaver.awlen;
      w_burst <= slaver.awburst;
      w_cnt   <= '0;
    end else if (w_hs) begin
      w_idx   <= next_idx(w_idx, w_burst);
      w_cnt   <= w_cnt + LSIZE'(1);
    end
  end

  // RAM write port, byte lanes gated by wstrb
  always_ff @(posedge clock) begin
    if (w_hs) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (slaver.wstrb[b]) mem[w_idx][b*8 +: 8] <= slaver.wdata[b*8 +: 8];
      end
    end
  end

  // ready is held low while reset is applied so every output reads 0
  assign slaver.awready = !rst && (w_state == W_IDLE);
  assign slaver.wready  = (w_state == W_DATA);
  assign slaver.bvalid  = (w_state == W_RESP);
  assign slaver.bid     = w_id;

  // ---------------- read side ----------------
  r_state_t          r_state, r_state_nxt;
  logic [IDSIZE-1:0] r_id;
  idx_t              r_idx;
  logic [LSIZE-1:0]  r_len, r_cnt;
  logic [1:0]        r_burst;
  logic [DSIZE-1:0]  rdata_q;
  logic              ar_hs, r_hs, r_last_beat, rd_en;

  assign ar_hs       = slaver.arvalid && slaver.arready;
  assign r_hs        = slaver.rvalid  && slaver.rready;
  assign r_last_beat = (r_cnt == r_len);
  // R_FETCH primes the registered read port; afterwards the next word is
  // fetched only when the current beat is accepted, so a stall holds data.
  assign rd_en       = (r_state == R_FETCH) || (r_hs && !r_last_beat);

  // read FSM state register
  always_ff @(posedge clock or posedge rst) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_state_nxt;
  end

  // read FSM next state
  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_FETCH;
      R_FETCH: r_state_nxt = R_DATA;
      R_DATA:  if (r_hs && r_last_beat) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // latch read burst attributes, then step fetch address and beat count
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_id    <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
    end else if (ar_hs) begin
      r_id    <= slaver.arid;
      r_idx   <= addr_to_idx(slaver.araddr);
      r_len   <= slaver.arlen;
      r_burst <= slaver.arburst;
      r_cnt   <= '0;
    end else begin
      if (rd_en) r_idx <= next_idx(r_idx, r_burst);
      if (r_hs)  r_cnt <= r_cnt + LSIZE'(1);
    end
  end

  // RAM read port; nonblocking update gives old data on a same-cycle write
  always_ff @(posedge clock) begin
    if (rd_en) rdata_q <= mem[r_idx];
  end

  assign slaver.arready = !rst && (r_state == R_IDLE);
  assign slaver.rvalid  = (r_state == R_DATA);
  assign slaver.rlast   = (r_state == R_DATA) && r_last_beat;
  assign slaver.rid     = r_id;
  assign slaver.rdata   = (r_state == R_DATA) ? rdata_q : '0;

  // ---------------- response codes ----------------
`ifdef AXI4_MEM_MODEL_SLVERR_EN
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] FULL_SIZE   = 3'(BSHIFT);

  logic w_err, r_err;

  // write error: bad burst/size at AW, or wlast not exactly on the last beat
  always_ff @(posedge clock or posedge rst) begin
    if (rst)                                   w_err <= 1'b0;
    else if (aw_hs)                            w_err <= (slaver.awburst == BURST_WRAP) ||
                                                        (slaver.awsize != FULL_SIZE);
    else if (w_hs && (slaver.wlast != w_last_beat)) w_err <= 1'b1;
  end

  // read error: bad burst/size at AR applies to every beat
  always_ff @(posedge clock or posedge rst) begin
    if (rst)        r_err <= 1'b0;
    else if (ar_hs) r_err <= (slaver.arburst == BURST_WRAP) || (slaver.arsize != FULL_SIZE);
  end

  assign slaver.bresp = ((w_state == W_RESP) && w_err) ? RESP_SLVERR : RESP_OKAY;
  assign slaver.rresp = ((r_state == R_DATA) && r_err) ? RESP_SLVERR : RESP_OKAY;

  logic unused_sigs;
  assign unused_sigs = ^{slaver.awlock, slaver.awcache, slaver.awprot, slaver.awqos,
                         slaver.arlock, slaver.arcache, slaver.arprot, slaver.arqos, MODE_OK};
`else
  assign slaver.bresp = RESP_OKAY;
  assign slaver.rresp = RESP_OKAY;

  logic unused_sigs;
  assign unused_sigs = ^{slaver.awlock, slaver.awcache, slaver.awprot, slaver.awqos,
                         slaver.arlock, slaver.arcache, slaver.arprot, slaver.arqos,
                         slaver.awsize, slaver.arsize, slaver.wlast, MODE_OK};
`endif

endmodule

// File: tb/tb_axi4_slaver_mem_model.sv
// Bench for axi4_slaver_mem_model: directed scenarios plus randomized
// write/read-back bursts compared against a word-array reference memory.
module tb_axi4_slaver_mem_model;
  localparam int DW = 32, IW = 4, AW = 32, LW = 8;
  localparam int DEPTH_LOG = 10;
  localparam int DEPTH = 1 << DEPTH_LOG;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_inf #(.IDSIZE(IW), .ASIZE(AW), .LSIZE(LW), .DSIZE(DW), .MODE("BOTH")) bus ();

  axi4_slaver_mem_model #(.DEPTH_LOG(DEPTH_LOG)) dut (
    .clock (clk),
    .rst   (rst),
    .slaver(bus)
  );

  logic [DW-1:0] ref_mem [DEPTH];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference rules: word index, per-beat step, response codes
  function automatic int word_of(input logic [AW-1:0] a);
    return int'(a / 4) % DEPTH;
  endfunction

  function automatic int step(input int i, input logic [1:0] burst);
    return (burst == 2'b00) ? i : (i + 1) % DEPTH;
  endfunction

  function automatic logic [1:0] exp_bresp(input logic [1:0] burst, input logic [2:0] size,
                                           input bit wlast_ok);
`ifdef AXI4_MEM_MODEL_SLVERR_EN
    return (burst == 2'b10 || size != 3'd2 || !wlast_ok) ? 2'b10 : 2'b00;
`else
    return 2'b00;
`endif
  endfunction

  function automatic logic [1:0] exp_rresp(input logic [1:0] burst, input logic [2:0] size);
`ifdef AXI4_MEM_MODEL_SLVERR_EN
    return (burst == 2'b10 || size != 3'd2) ? 2'b10 : 2'b00;
`else
    return 2'b00;
`endif
  endfunction

  task automatic idle_bus();
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'd2; bus.awburst = 2'b01;
    bus.awlock = 1'b0; bus.awcache = '0; bus.awprot = '0; bus.awqos = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'd2; bus.arburst = 2'b01;
    bus.arlock = 1'b0; bus.arcache = '0; bus.arprot = '0; bus.arqos = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
  endtask

  // Full write burst; wvalid held high. Starts and ends just after a rising edge.
  task automatic axi_write(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                           input logic [1:0] burst, input logic [2:0] size, input int last_at,
                           input logic [DW-1:0] data[$], input logic [DW/8-1:0] strb[$],
                           input bit rnd_bready);
    int wi, cyc, beat, waitc;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len[LW-1:0];
    bus.awsize = size; bus.awburst = burst; bus.awvalid = 1'b1;
    waitc = 0;
    do begin @(negedge clk); waitc++; end while (!bus.awready && waitc < 100);
    chk("aw_ready", bus.awready, 1'b1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    wi = word_of(addr); beat = 0; cyc = 0;
    while (beat <= len && cyc < 4 * (len + 1) + 10) begin
      bus.wvalid = 1'b1; bus.wdata = data[beat]; bus.wstrb = strb[beat];
      bus.wlast = (beat == last_at);
      @(negedge clk); cyc++;
      if (bus.wready) begin
        for (int b = 0; b < DW / 8; b++)
          if (strb[beat][b]) ref_mem[wi][b*8 +: 8] = data[beat][b*8 +: 8];
        wi = step(wi, burst); beat++;
      end
      @(posedge clk); #1;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    chk("w_cycles", cyc, len + 1);
    bus.bready = rnd_bready ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    chk("b_valid_lat", bus.bvalid, 1'b1);
    waitc = 0;
    while (!(bus.bvalid && bus.bready) && waitc < 100) begin
      @(posedge clk); #1;
      bus.bready = 1'($urandom_range(0, 1));
      @(negedge clk); waitc++;
    end
    chk("b_id", bus.bid, id);
    chk("b_resp", bus.bresp, exp_bresp(burst, size, last_at == len));
    @(posedge clk); #1;
    bus.bready = 1'b0;
    @(negedge clk);
    chk("aw_ready_ret", bus.awready, 1'b1);
    @(posedge clk); #1;
  endtask

  // Read burst; rmode 0: rready high, 1: toggles 1,0,1,0.., 2: random.
  task automatic axi_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                          input logic [1:0] burst, input logic [2:0] size, input int rmode);
    int wi, beat, k, waitc;
    bus.arid = id; bus.araddr = addr; bus.arlen = len[LW-1:0];
    bus.arsize = size; bus.arburst = burst; bus.arvalid = 1'b1;
    waitc = 0;
    do begin @(negedge clk); waitc++; end while (!bus.arready && waitc < 100);
    chk("ar_ready", bus.arready, 1'b1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0; bus.rready = 1'b0;
    @(negedge clk);
    chk("r_lat_early", bus.rvalid, 1'b0);
    @(posedge clk); #1;
    wi = word_of(addr); beat = 0; k = 0;
    while (beat <= len && k < 8 * (len + 1) + 10) begin
      case (rmode)
        0:       bus.rready = 1'b1;
        1:       bus.rready = (k % 2 == 0);
        default: bus.rready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (k == 0) chk("r_lat", bus.rvalid, 1'b1);
      if (bus.rvalid) begin
        chk("r_data", bus.rdata, ref_mem[wi]);
        chk("r_last", bus.rlast, beat == len);
        chk("r_id", bus.rid, id);
        chk("r_resp", bus.rresp, exp_rresp(burst, size));
        if (bus.rready) begin
          wi = step(wi, burst); beat++;
        end
      end
      @(posedge clk); #1; k++;
    end
    bus.rready = 1'b0;
    chk("r_beats", beat, len + 1);
    @(negedge clk);
    chk("ar_ready_ret", bus.arready, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0]   dq[$];
    logic [DW/8-1:0] sq[$];
    logic [DW-1:0]   old_val, new_val;
    logic [AW-1:0]   a;
    int              hs, len, wd;
    logic [1:0]      bt;
    logic [2:0]      sz;

    idle_bus();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", bus.awready, 1'b0);
    chk("rst_wready",  bus.wready,  1'b0);
    chk("rst_bvalid",  bus.bvalid,  1'b0);
    chk("rst_arready", bus.arready, 1'b0);
    chk("rst_rvalid",  bus.rvalid,  1'b0);
    chk("rst_rlast",   bus.rlast,   1'b0);
    chk("rst_bid",     bus.bid,     '0);
    chk("rst_bresp",   bus.bresp,   '0);
    chk("rst_rid",     bus.rid,     '0);
    chk("rst_rdata",   bus.rdata,   '0);
    chk("rst_rresp",   bus.rresp,   '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rel_awready", bus.awready, 1'b1);
    chk("rel_arready", bus.arready, 1'b1);
    @(posedge clk); #1;

    // fill the whole RAM so every later read has a known value
    for (int blk = 0; blk < 4; blk++) begin
      dq.delete(); sq.delete();
      for (int i = 0; i < 256; i++) begin dq.push_back($urandom); sq.push_back(4'hF); end
      axi_write(4'(blk), AW'(blk * 1024), 255, 2'b01, 3'd2, 255, dq, sq, 1'b0);
    end

    // single beat write then read
    dq = '{32'hDEADBEEF}; sq = '{4'hF};
    axi_write(4'h5, 32'h40, 0, 2'b01, 3'd2, 0, dq, sq, 1'b0);
    axi_read(4'h3, 32'h40, 0, 2'b01, 3'd2, 0);

    // INCR 16 beats from 0, read back with rready toggling
    dq.delete(); sq.delete();
    for (int i = 0; i < 16; i++) begin dq.push_back(DW'(i)); sq.push_back(4'hF); end
    axi_write(4'h1, 32'h0, 15, 2'b01, 3'd2, 15, dq, sq, 1'b0);
    axi_read(4'h2, 32'h0, 15, 2'b01, 3'd2, 1);

    // partial strobe
    dq = '{32'hFFFFFFFF}; sq = '{4'hF};
    axi_write(4'h6, 32'h100, 0, 2'b01, 3'd2, 0, dq, sq, 1'b0);
    dq = '{32'h00000000}; sq = '{4'b0101};
    axi_write(4'h6, 32'h100, 0, 2'b01, 3'd2, 0, dq, sq, 1'b0);
    axi_read(4'h7, 32'h100, 0, 2'b01, 3'd2, 0);

    // FIXED burst lands every beat on one word; neighbour untouched
    dq = '{32'd1, 32'd2, 32'd3, 32'd4}; sq = '{4'hF, 4'hF, 4'hF, 4'hF};
    axi_write(4'h8, 32'h200, 3, 2'b00, 3'd2, 3, dq, sq, 1'b0);
    axi_read(4'h9, 32'h200, 0, 2'b01, 3'd2, 0);
    axi_read(4'h9, 32'h204, 0, 2'b01, 3'd2, 0);
    axi_read(4'h9, 32'h200, 3, 2'b00, 3'd2, 2);

    // INCR wrapping past the top word, read through an aliased address
    dq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3}; sq = '{4'hF, 4'hF, 4'hF, 4'hF};
    axi_write(4'hA, 32'hFF8, 3, 2'b01, 3'd2, 3, dq, sq, 1'b0);
    axi_read(4'hB, 32'h8000_0FF8, 3, 2'b01, 3'd2, 0);

    // WRAP write and early wlast
    dq = '{32'h11, 32'h22, 32'h33, 32'h44}; sq = '{4'hF, 4'hF, 4'hF, 4'hF};
    axi_write(4'hC, 32'h300, 3, 2'b10, 3'd2, 3, dq, sq, 1'b0);
    axi_read(4'hC, 32'h300, 3, 2'b10, 3'd2, 0);
    axi_write(4'hD, 32'h340, 3, 2'b01, 3'd2, 2, dq, sq, 1'b0);
    axi_read(4'hD, 32'h340, 3, 2'b01, 3'd2, 0);

    // same-cycle write and read of one word returns the old value
    old_val = ref_mem[word_of(32'h500)];
    new_val = 32'hC0FFEE01;
    bus.awid = 4'h2; bus.awaddr = 32'h500; bus.awlen = '0; bus.awburst = 2'b01; bus.awvalid = 1'b1;
    bus.wdata = new_val; bus.wstrb = 4'hF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
    bus.arid = 4'h4; bus.araddr = 32'h500; bus.arlen = '0; bus.arburst = 2'b01; bus.arvalid = 1'b1;
    @(negedge clk);
    chk("col_awready", bus.awready, 1'b1);
    chk("col_arready", bus.arready, 1'b1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.arvalid = 1'b0; bus.rready = 1'b1;
    @(negedge clk);
    chk("col_wready", bus.wready, 1'b1);
    @(posedge clk); #1;
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    @(negedge clk);
    chk("col_rvalid", bus.rvalid, 1'b1);
    chk("col_rdata_old", bus.rdata, old_val);
    chk("col_bvalid", bus.bvalid, 1'b1);
    ref_mem[word_of(32'h500)] = new_val;
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0; bus.rready = 1'b0;
    @(negedge clk);
    chk("col_awready_ret", bus.awready, 1'b1);
    chk("col_arready_ret", bus.arready, 1'b1);
    @(posedge clk); #1;
    axi_read(4'h4, 32'h500, 0, 2'b01, 3'd2, 0);

    // reset in the middle of a 16-beat write, after five beats
    bus.awid = 4'hE; bus.awaddr = 32'h600; bus.awlen = 8'd15; bus.awburst = 2'b01; bus.awvalid = 1'b1;
    @(negedge clk);
    chk("mid_awready", bus.awready, 1'b1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    hs = 0; wd = word_of(32'h600);
    for (int c = 0; c < 40 && hs < 5; c++) begin
      new_val = $urandom;
      bus.wvalid = 1'b1; bus.wdata = new_val; bus.wstrb = 4'hF; bus.wlast = 1'b0;
      @(negedge clk);
      if (bus.wready) begin ref_mem[wd] = new_val; wd = step(wd, 2'b01); hs++; end
      @(posedge clk); #1;
    end
    chk("mid_beats", hs, 5);
    rst = 1'b1;
    idle_bus();
    @(negedge clk);
    chk("mid_rst_awready", bus.awready, 1'b0);
    chk("mid_rst_wready",  bus.wready,  1'b0);
    chk("mid_rst_bvalid",  bus.bvalid,  1'b0);
    chk("mid_rst_arready", bus.arready, 1'b0);
    chk("mid_rst_rvalid",  bus.rvalid,  1'b0);
    chk("mid_rst_bid",     bus.bid,     '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rel_awready", bus.awready, 1'b1);
    chk("mid_rel_bvalid",  bus.bvalid,  1'b0);
    chk("mid_rel_wready",  bus.wready,  1'b0);
    @(posedge clk); #1;
    axi_read(4'hF, 32'h600, 5, 2'b01, 3'd2, 0);

    // randomized bursts with aliasing addresses, random strobes and stalls
    for (int t = 0; t < 30; t++) begin
      dq.delete(); sq.delete();
      len = $urandom_range(0, 15);
      bt  = 2'($urandom_range(0, 2));
      sz  = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd2;
      a   = ($urandom & 32'hFFFF_F000) | AW'($urandom_range(0, DEPTH - 1) * 4);
      for (int i = 0; i <= len; i++) begin dq.push_back($urandom); sq.push_back(4'($urandom)); end
      axi_write(4'($urandom), a, len, bt, sz, len, dq, sq, 1'b1);
      axi_read(4'($urandom), a, len, bt, sz, 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
